seq_divider: RTL and testbench

- Multi-cycle restoring divider; the inverse of the registered (A+B)*C multiply datapath.
- Takes a wide product and its 32-bit multiplier, and recovers the quotient (the original A+B sum) and the remainder.
- Processes one quotient bit per clock, MSB first, under a start/busy/done handshake.
- Sits downstream of the multiply stage as its checking/decoding partner in the hw5 timing-analysis designs.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 81 ++++++++
 tb/tb_seq_divider.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// busy/done handshake and held results out.
interface seq_divider_if #(
  parameter int DIVIDEND_W = 258,
  parameter int DIVISOR_W  = 32
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock MSB first; recovers (A+B) and
// the remainder from a registered (A+B)*C product and its multiplier C.
module seq_divider #(
  parameter int DIVIDEND_W = 258,
  parameter int DIVISOR_W  = 32
) (
  input  logic          clock,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after DIVIDEND_W shifts this register holds the quotient.
  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  prem;

  logic [DIVISOR_W:0]    rem_shift;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_low;
  logic [DIVIDEND_W-1:0] q_next;

  // The shifted partial remainder carries one extra bit so the compare never
  // overflows; after the subtract it always fits back into DIVISOR_W bits.
  // With a zero divisor every compare succeeds, so the quotient fills with
  // ones and the low dividend bits fall through as the remainder.
  always_comb begin
    rem_shift = {prem, dvd_sr[DIVIDEND_W-1]};
    ge        = (rem_shift >= {1'b0, dvs});
    rem_low   = ge ? (rem_shift[DIVISOR_W-1:0] - dvs) : rem_shift[DIVISOR_W-1:0];
    q_next    = {dvd_sr[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      dvd_sr          <= '0;
      dvs             <= '0;
      prem            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_sr   <= bus.dividend;
            dvs      <= bus.divisor;
            prem     <= '0;
            cnt      <= CNT_W'(DIVIDEND_W);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          dvd_sr <= q_next;
          prem   <= rem_low;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= q_next;
            bus.remainder   <= rem_low;
            bus.div_by_zero <= (dvs == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operands with hand-computed
// results, a monitor that checks every done pulse against the queue.
module tb_seq_divider;
  localparam int DW  = 258;
  localparam int SW  = 32;
  localparam int LAT = DW + 1;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          z;
    int            cyc;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  seq_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", DW'(bus.remainder), DW'(e.r));
        check("div_by_zero", DW'(bus.div_by_zero), DW'(e.z));
        check("done_cycle", DW'(cyc), DW'(e.cyc));
      end
    end
  end

  // Called at a negedge; the start is taken on the following posedge.
  task automatic issue(input logic [DW-1:0] dvd, input logic [SW-1:0] dvs,
                       input logic [DW-1:0] eq, input logic [SW-1:0] er, input logic ez);
    exp_t e;
    e.q = eq; e.r = er; e.z = ez; e.cyc = cyc + LAT;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_run", DW'(bus.busy), DW'(1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      if (bus.done) return;
      @(negedge clock);
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=0 required=1");
  endtask

  task automatic post_done(input logic [DW-1:0] eq, input logic [SW-1:0] er);
    @(negedge clock);
    check("done_low", DW'(bus.done), DW'(0));
    check("busy_idle", DW'(bus.busy), DW'(0));
    check("quotient_held", bus.quotient, eq);
    check("remainder_held", DW'(bus.remainder), DW'(er));
  endtask

  task automatic run(input logic [DW-1:0] dvd, input logic [SW-1:0] dvs,
                     input logic [DW-1:0] eq, input logic [SW-1:0] er, input logic ez);
    issue(dvd, dvs, eq, er, ez);
    wait_done();
    post_done(eq, er);
  endtask

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] big;
    logic [DW-1:0] p128;
    ones = '1;
    p128 = DW'(1) << 128;
    big  = (DW'(1) << 160) - p128;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", DW'(bus.busy), DW'(0));
    check("rst_done", DW'(bus.done), DW'(0));
    check("rst_quotient", bus.quotient, DW'(0));
    check("rst_remainder", DW'(bus.remainder), DW'(0));
    check("rst_dbz", DW'(bus.div_by_zero), DW'(0));
    reset = 1'b0;
    @(negedge clock);

    run(DW'(56), 32'd7, DW'(8), 32'd0, 1'b0);
    run(DW'(100), 32'd7, DW'(14), 32'd2, 1'b0);
    run(big, 32'hFFFF_FFFF, p128, 32'd0, 1'b0);
    run(ones, 32'd1, ones, 32'd0, 1'b0);
    run(DW'(5), 32'hFFFF_FFFF, DW'(0), 32'd5, 1'b0);
    run(DW'(64'h1_2345_6789), 32'd0, ones, 32'h2345_6789, 1'b1);
    run(DW'(0), 32'd5, DW'(0), 32'd0, 1'b0);

    // A second start mid-divide must be ignored.
    issue(DW'(1000), 32'd10, DW'(100), 32'd0, 1'b0);
    repeat (9) @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = DW'(77);
    bus.divisor  = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_ignore", DW'(bus.busy), DW'(1));
    wait_done();
    // Restart on the edge right after done; old result must hold meanwhile.
    issue(DW'(3000), 32'd7, DW'(428), 32'd4, 1'b0);
    check("quotient_hold_run", bus.quotient, DW'(100));
    wait_done();
    post_done(DW'(428), 32'd4);

    // Reset mid-divide with start asserted: abort, clear, never complete.
    bus.start    = 1'b1;
    bus.dividend = DW'(999);
    bus.divisor  = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (99) @(negedge clock);
    reset     = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    check("abort_busy", DW'(bus.busy), DW'(0));
    check("abort_done", DW'(bus.done), DW'(0));
    check("abort_quotient", bus.quotient, DW'(0));
    check("abort_remainder", DW'(bus.remainder), DW'(0));
    check("abort_dbz", DW'(bus.div_by_zero), DW'(0));
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (300) @(negedge clock);
    check("abort_no_done_busy", DW'(bus.busy), DW'(0));
    check("scoreboard_empty", DW'(sb.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
